// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory access controller:
// access sizes, controller states and load-extension codes.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    EXT_NONE   = 3'd0,
    EXT_HALF_Z = 3'd1,
    EXT_HALF_S = 3'd2,
    EXT_BYTE_Z = 3'd3,
    EXT_BYTE_S = 3'd4
  } ext_t;

  function automatic ext_t ext_code(input logic [1:0] size, input logic sgn);
    case (size)
      SZ_HALF: return sgn ? EXT_HALF_S : EXT_HALF_Z;
      SZ_BYTE: return sgn ? EXT_BYTE_S : EXT_BYTE_Z;
      default: return EXT_NONE;
    endcase
  endfunction

  // Reserved size 3 must already be folded to word by the caller.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_BYTE: return 1'b0;
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ext.sv
// Selects the addressed byte/halfword lane of a read word and
// zero- or sign-extends it to 32 bits.
module dmem_lane_ext
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  logic [15:0] lane_h;
  logic [7:0]  lane_b;

  always_comb begin
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    lane_b = 8'(word >> {addr_lo, 3'b000});
    case (ext_code(size, sgn))
      EXT_HALF_Z: ext = {16'h0000, lane_h};
      EXT_HALF_S: ext = {{16{lane_h[15]}}, lane_h};
      EXT_BYTE_Z: ext = {24'h000000, lane_b};
      EXT_BYTE_S: ext = {{24{lane_b[7]}}, lane_b};
      default:    ext = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer for a variable-latency word-wide data
// memory: stalls the pipeline, shapes lanes, and reports misalign/timeouts.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic              we_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [31:0]       addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]  size_eff;
  logic        req_mis;
  logic        accept;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ext_rdata;

  always_comb begin
    size_eff = (req_size == 2'd3) ? SZ_WORD : req_size;
    req_mis  = is_misaligned(size_eff, req_addr[1:0]);
    accept   = (state == S_IDLE) && req_valid && !req_mis;
    case (size_eff)
      SZ_HALF: begin
        be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
    endcase
  end

  dmem_lane_ext u_lane_ext (
    .size    (size_q),
    .sgn     (sgn_q),
    .addr_lo (off_q),
    .word    (mem_rdata),
    .ext     (ext_rdata)
  );

  // Memory-side fields come only from registers, so they are stable for the
  // whole BUSY window and read as zero out of reset.
  always_comb begin
    stall      = accept || (state == S_BUSY);
    misalign   = (state == S_IDLE) && req_valid && req_mis;
    mem_req    = (state == S_BUSY);
    mem_we     = mem_req && we_q;
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_be     = be_q;
    mem_wdata  = wdata_q;
    resp_valid = (state == S_RESP);
    bus_err    = resp_valid && err_q;
    resp_rdata = rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= SZ_WORD;
      off_q   <= 2'b00;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_BUSY;
            we_q    <= req_we;
            sgn_q   <= req_signed;
            size_q  <= size_eff;
            off_q   <= req_addr[1:0];
            addr_q  <= req_addr;
            be_q    <= be_next;
            wdata_q <= wdata_next;
            err_q   <= 1'b0;
            cnt     <= '0;
          end
        end
        S_BUSY: begin
          // A ready in the timeout cycle still completes the access cleanly.
          if (mem_ready) begin
            state   <= S_RESP;
            rdata_q <= we_q ? 32'h0 : ext_rdata;
            err_q   <= 1'b0;
            cnt     <= '0;
          end else if (cnt == TO_LAST) begin
            state   <= S_RESP;
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, reset-in-flight
// sequence and randomized accesses against a byte-arithmetic model.
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, misalign, bus_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // delay = number of BUSY cycles before the one carrying mem_ready;
  // delay >= TO means the memory never answers.
  task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay,
                           input logic use_tab, input logic [3:0] tab_be,
                           input logic [31:0] tab_rd, input string tag);
    int nb, off, busy_n, stall_cnt;
    logic mis, tmo;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_rd, mask, v;
    nb   = (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 4;
    off  = int'(addr[1:0]);
    mis  = (off % nb) != 0;
    e_be = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 1);
    v    = (rdata >> (8*off)) & mask;
    if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
    tmo    = delay >= TO;
    busy_n = tmo ? TO : delay + 1;
    e_rd   = (we || tmo) ? 32'h0 : v;
    if (use_tab) begin
      e_be = tab_be;
      e_rd = tab_rd;
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, " misalign"}, 32'(misalign), 32'(mis));
    chk({tag, " idle mem_req"}, 32'(mem_req), 32'd0);
    stall_cnt = int'(stall);
    if (mis) begin
      chk({tag, " misalign stall"}, 32'(stall), 32'd0);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      chk({tag, " misalign drops"}, {31'd0, misalign}, 32'd0);
      chk({tag, " no mem_req"}, 32'(mem_req), 32'd0);
      return;
    end
    for (int k = 0; k < busy_n; k++) begin
      @(posedge clk); #1;
      mem_ready = (k == delay);
      mem_rdata = rdata;
      @(negedge clk);
      chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
      chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
      chk({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      chk({tag, " mem_be"}, 32'(mem_be), 32'(e_be));
      chk({tag, " mem_wdata"}, mem_wdata, e_wd);
      stall_cnt += int'(stall);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    @(negedge clk);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " bus_err"}, 32'(bus_err), 32'(tmo));
    chk({tag, " resp_rdata"}, resp_rdata, e_rd);
    chk({tag, " resp mem_req"}, 32'(mem_req), 32'd0);
    stall_cnt += int'(stall);
    chk({tag, " stall cycles"}, 32'(stall_cnt), 32'(1 + busy_n));
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk({tag, " resp_valid pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, " bus_err pulse"}, 32'(bus_err), 32'd0);
    chk({tag, " idle stall"}, 32'(stall), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  be;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h100, 32'h0,    32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'd2, 1'b1, 32'h103, 32'h0,    32'h80123456, 0, 4'b1000, 32'hFFFFFF80};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h103, 32'h0,    32'h80123456, 0, 4'b1000, 32'h00000080};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h22,  32'hABCD, 32'h0,        3, 4'b1100, 32'h0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h41,  32'h0,    32'h0,        0, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h200, 32'h0,    32'h11111111, 9, 4'b1111, 32'h0};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h204, 32'h0,    32'h12345678, 3, 4'b1111, 32'h12345678};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h42,  32'h0,    32'h80017FFF, 1, 4'b1100, 32'hFFFF8001};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h21,  32'h5A,   32'h0,        2, 4'b0010, 32'h0};
    vecs[9]  = '{1'b0, 2'd3, 1'b1, 32'h10,  32'h0,    32'hCAFEF00D, 0, 4'b1111, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h102, 32'h1,    32'h0,        0, 4'b0000, 32'h0};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h40,  32'h0,    32'h1234F00D, 1, 4'b0011, 32'h0000F00D};
    vecs[12] = '{1'b0, 2'd2, 1'b1, 32'h102, 32'h0,    32'h007F0000, 0, 4'b0100, 32'h0000007F};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      do_access(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                vecs[i].rdata, vecs[i].delay, 1'b1, vecs[i].be, vecs[i].rd,
                $sformatf("vec%0d", i));

    // Reset while the memory is still working on an access.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_addr = 32'h300; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst busy mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst async mem_req", 32'(mem_req), 32'd0);
    chk("rst async stall", 32'(stall), 32'd0);
    chk("rst async resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_access(1'b0, 2'd0, 1'b0, 32'h304, 32'h0, 32'hA5A5_0F0F, 1, 1'b1, 4'b1111,
              32'hA5A5_0F0F, "post-reset");

    for (int i = 0; i < 60; i++)
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, int'($urandom_range(0, 5)), 1'b0, 4'h0,
                32'h0, $sformatf("rnd%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage loads/stores onto a variable-latency, word-wide data memory using a req/ready handshake.
- Generates the word address, byte enables and lane-replicated store data.
- Extends loaded bytes/halfwords to 32 bits (zero or sign) and holds the pipeline stalled until the access completes.
- Sits between the MEM-stage pipeline register and the data memory. Flags misaligned accesses and memory timeouts to the exception logic.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ready before aborting with bus_err; 1..255.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage has a load/store this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = word, 1 = half, 2 = byte; 3 = reserved, treated as word
- req_signed  in  1  load sign-extends when 1; ignored for word and stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  freeze PC/IF/ID/EX/MEM registers
- resp_valid  out  1  one-cycle pulse: access finished, resp_rdata valid for loads
- resp_rdata  out  32  extended load data
- misalign  out  1  one-cycle pulse: address misaligned for req_size
- bus_err  out  1  one-cycle pulse with resp_valid when the access timed out
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  32  word address, {req_addr[31:2], 2'b00}
- mem_be  out  4  byte enables; bit i = byte lane [8i+7:8i]
- mem_wdata  out  32  store data replicated to all lanes
- mem_ready  in  1  memory completes the access in this cycle
- mem_rdata  in  32  read word, valid when mem_ready && !mem_we

Behaviour:
- Reset state: IDLE. All outputs 0. Counter 0. Captured request registers 0.
- FSM states: IDLE, BUSY, RESP. Reset may assert mid-access; mem_req drops immediately (asynchronous).
- Misalignment rule: half requires addr[0] = 0; word requires addr[1:0] = 0; byte is never misaligned.
- IDLE, req_valid and aligned:
  - Latch we, size, signed, addr[1:0], addr and wdata; go to BUSY.
  - stall = 1 combinationally in this cycle.
- IDLE, req_valid and misaligned:
  - misalign = 1 this cycle (combinational). stall = 0. No memory access. Remain in IDLE.
- BUSY:
  - mem_req = 1. mem_we, mem_addr, mem_be and mem_wdata come from latched values and are stable until mem_ready.
  - stall = 1. The counter increments each cycle.
  - mem_ready = 1: capture extended mem_rdata (loads) into resp_rdata; go to RESP; clear the counter.
  - Counter reaches TIMEOUT_CYCLES without mem_ready: drop mem_req, set resp_rdata = 0, set the bus_err flag, go to RESP.
  - A mem_ready arriving in the same cycle as the timeout takes priority; no bus_err.
- RESP:
  - resp_valid = 1 (and bus_err if flagged). stall = 0, so the pipeline advances at this edge.
  - Always go to IDLE; the request present during RESP is the same instruction and is not re-accepted.
- Byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: 1 << addr[1:0].
  - Loads drive the same be pattern; memory may ignore it.
- Store data lanes:
  - word: wdata.
  - half: {wdata[15:0], wdata[15:0]}.
  - byte: {4{wdata[7:0]}}.
- Load extension selects the lane by latched addr[1:0]:
  - half: addr[1] picks [31:16] or [15:0].
  - byte: lane addr[1:0].
  - Zero-extend, or sign-extend from the lane MSB when req_signed.
  - word: pass through.
- Stores: resp_rdata = 0.
- Minimum access latency is 3 cycles (IDLE, BUSY, RESP) with mem_ready asserted on the first BUSY cycle.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings SZ_WORD = 2'd0, SZ_HALF = 2'd1, SZ_BYTE = 2'd2.
  - FSM state encodings S_IDLE, S_BUSY, S_RESP.
  - The load-extension type codes used by the writeback extender: 0 none, 1 half zero, 2 half sign, 3 byte zero, 4 byte sign.
- One combinational sub-module, dmem_lane_ext: inputs size, signed, addr[1:0] and a 32-bit word; output the extended 32-bit result.
- Byte-enable/replication logic stays inline.

Test Plan:
- Word load, addr 0x100, mem_ready on first BUSY cycle, mem_rdata 0xDEADBEEF → mem_be 1111; resp_rdata 0xDEADBEEF; stall high exactly 2 cycles.
- Signed byte load, addr 0x103, mem_rdata 0x80123456 → mem_be 1000; resp_rdata 0xFFFFFF80. Unsigned variant → 0x00000080.
- Half store, addr 0x22, wdata 0x0000ABCD, mem_ready after 4 BUSY cycles → mem_addr 0x20, mem_be 1100, mem_wdata 0xABCDABCD held stable all 4 cycles, resp_valid once.
- Half load at addr 0x41 → misalign pulse one cycle, mem_req never asserts, stall 0.
- TIMEOUT_CYCLES = 4, mem_ready tied 0 → mem_req high 4 cycles then low; resp_valid and bus_err pulse together; resp_rdata 0; back to IDLE.
- rst_n low during BUSY → mem_req and stall drop asynchronously. After release, a new word load completes normally.
